// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the memory port arbiter slice:
//     - default address/data widths matching memory_block
//     - FSM state encoding used by mem_port_arbiter
//     - port identifiers and a helper returning the opposite port
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 32;

    // 2'b11 is unused and recovers to ST_IDLE in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } arb_state_t;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter.
//   Ports:
//     clk, reset  rising-edge clock, synchronous active-high reset
//     req[1:0]    {port1, port0} requests
//     grant_en    commit the current grant (updates last_grant)
//     grant[1:0]  one-hot combinational grant, 2'b00 when no request
//   last_grant resets to port 1 so that port 0 wins the first tie.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (other_port(last_grant) == PORT_1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_1;
        end else if (grant_en && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares memory_block between port 0 (load/store unit) and port 1
//   (secondary master). A winning request is latched, presented to memory
//   for exactly one ACCESS cycle, read data is captured at the end of that
//   cycle, and a one-cycle ack is returned in DONE.
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-high reset
//     rN_req/we/byte        request, write enable, byte operation
//     rN_addr/rN_wdata      request address and write data
//     rN_ack                one-cycle completion pulse
//     rN_rdata              last read result for that port
//     mem_addr/wdata/byte   latched request fields to memory_block
//     mem_read/mem_write    memory strobes, high only during ACCESS
//     mem_rdata             combinational read data from memory_block
//     busy                  high in ACCESS and DONE
//   Timing: request sampled at edge N, strobe in cycle N+1, ack in cycle N+2.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_byte,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_byte,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t state;
    logic       lat_we;
    logic       lat_id;

    logic [1:0] grant;
    logic       grant_en;
    logic       sel;

    logic              sel_we;
    logic              sel_byte;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Arbitration only happens from IDLE; requests in ACCESS/DONE wait.
    assign grant_en = (state == ST_IDLE) && (r0_req || r1_req);

    rr_arbiter2 u_rr_arbiter2 (
        .clk      (clk),
        .reset    (reset),
        .req      ({r1_req, r0_req}),
        .grant_en (grant_en),
        .grant    (grant)
    );

    assign sel       = grant[1];
    assign sel_we    = sel ? r1_we    : r0_we;
    assign sel_byte  = sel ? r1_byte  : r0_byte;
    assign sel_addr  = sel ? r1_addr  : r0_addr;
    assign sel_wdata = sel ? r1_wdata : r0_wdata;

    // mem_addr/mem_wdata/mem_byte double as the latched request fields, so
    // they hold their last value between accesses instead of toggling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lat_we    <= 1'b0;
            lat_id    <= PORT_0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_byte  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            busy      <= 1'b0;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        lat_id    <= sel;
                        lat_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_byte  <= sel_byte;
                        mem_read  <= ~sel_we;
                        mem_write <= sel_we;
                        busy      <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // memory_block read data is combinational on mem_addr,
                    // so it is valid at the edge that closes ACCESS.
                    if (!lat_we) begin
                        if (lat_id == PORT_1) begin
                            r1_rdata <= mem_rdata;
                        end else begin
                            r0_rdata <= mem_rdata;
                        end
                    end
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    r0_ack    <= (lat_id == PORT_0);
                    r1_ack    <= (lat_id == PORT_1);
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter with a behavioural memory_block model and a
//   reference model (expected memory contents, per-port read registers and
//   the round-robin rule expressed as "on a tie, the port not served last").
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 18;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_we, r0_byte;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_ack;
    logic [DW-1:0] r0_rdata;
    logic          r1_req, r1_we, r1_byte;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_ack;
    logic [DW-1:0] r1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read, mem_write, mem_byte;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_byte   (r0_byte),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ack    (r0_ack),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_byte   (r1_byte),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ack    (r1_ack),
        .r1_rdata  (r1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_byte  (mem_byte),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // memory_block stand-in: combinational read, write on the clock edge.
    logic [DW-1:0] env_mem [0:1023];
    assign mem_rdata = env_mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_write === 1'b1) env_mem[mem_addr[9:0]] = mem_wdata;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] exp_rdata [0:1];
    int            model_last;

    task automatic model_reset();
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        model_last   = 1;
    endtask

    task automatic model_apply(input int port, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
        if (we) ref_mem[addr[9:0]] = wdata;
        else    exp_rdata[port]    = ref_mem[addr[9:0]];
        model_last = port;
    endtask

    // Protocol monitor, sampled just after each rising edge.
    bit   mon_en = 1'b0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL strobe_excl: mem_read=%b mem_write=%b, required not both 1", mem_read, mem_write);
            end
            checks++;
            if ((r0_ack && r1_ack) || (r0_ack && prev0) || (r1_ack && prev1)) begin
                errors++;
                $display("FAIL ack_onehot: r0_ack=%b r1_ack=%b prev=%b%b, required one-hot single-cycle",
                         r0_ack, r1_ack, prev0, prev1);
            end
            checks++;
            if ((r0_ack && !r0_req) || (r1_ack && !r1_req)) begin
                errors++;
                $display("FAIL ack_req: ack=%b%b req=%b%b, required ack only for pending req",
                         r1_ack, r0_ack, r1_req, r0_req);
            end
            checks++;
            if ((mem_read || mem_write) && !busy) begin
                errors++;
                $display("FAIL strobe_busy: strobe with busy=%b, required busy=1", busy);
            end
        end
        prev0 = r0_ack;
        prev1 = r1_ack;
    end

    task automatic set_req(input int port, input bit we, input bit byt,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            r0_req = 1'b1; r0_we = we; r0_byte = byt; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_byte = byt; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One request on one port; observes strobes and ack latency.
    task automatic run_single(input int port, input bit we, input bit byt,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              output int lat, output int n_rd, output int n_wr,
                              output logic [AW-1:0] s_addr, output logic [DW-1:0] s_wdata,
                              output logic s_byte, output bit timeout);
        logic ack;
        @(negedge clk);
        set_req(port, we, byt, addr, wdata);
        lat = 0; n_rd = 0; n_wr = 0; timeout = 1'b1;
        s_addr = 'x; s_wdata = 'x; s_byte = 1'bx;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                s_addr = mem_addr; s_wdata = mem_wdata; s_byte = mem_byte;
            end
            if (mem_read)  n_rd++;
            if (mem_write) n_wr++;
            ack = (port == 0) ? r0_ack : r1_ack;
            if (ack) begin
                lat = cyc;
                timeout = 1'b0;
                if (port == 0) r0_req = 1'b0; else r1_req = 1'b0;
                break;
            end
        end
        if (timeout) begin
            r0_req = 1'b0; r1_req = 1'b0;
        end else begin
            model_apply(port, we, addr, wdata);
        end
    endtask

    // Both ports request on the same edge; returns who was served first and
    // the ack spacing.
    task automatic run_both(input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                            output int first, output int gap, output bit timeout);
        int  t0, t1;
        bit  got0, got1;
        @(negedge clk);
        set_req(0, we0, 1'b0, a0, d0);
        set_req(1, we1, 1'b0, a1, d1);
        got0 = 0; got1 = 0; t0 = 0; t1 = 0; timeout = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (r0_ack && !got0) begin got0 = 1; t0 = cyc; r0_req = 1'b0; end
            if (r1_ack && !got1) begin got1 = 1; t1 = cyc; r1_req = 1'b0; end
            if (got0 && got1) begin timeout = 1'b0; break; end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        first = (t0 <= t1) ? 0 : 1;
        gap   = (first == 0) ? (t1 - t0) : (t0 - t1);
        if (!timeout) begin
            if (model_last == 1) begin
                model_apply(0, we0, a0, d0); model_apply(1, we1, a1, d1);
            end else begin
                model_apply(1, we1, a1, d1); model_apply(0, we0, a0, d0);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({r0_ack, r1_ack, mem_read, mem_write, mem_byte, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack/strobe/byte/busy=%b, required 000000",
                     {r0_ack, r1_ack, mem_read, mem_write, mem_byte, busy});
        end
        checks++;
        if ({r0_rdata, r1_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: r0=%h r1=%h, required 0", r0_rdata, r1_rdata);
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 50'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_read, mem_write, r0_ack, r1_ack} !== 5'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy/strobes/acks=%b, required 00000",
                     {busy, mem_read, mem_write, r0_ack, r1_ack});
        end
    endtask

    task automatic test_write_read();
        int lat, n_rd, n_wr; logic [AW-1:0] sa; logic [DW-1:0] sw; logic sb; bit to;
        run_single(0, 1'b1, 1'b0, 18'h00008, 32'hFFFFFFFF, lat, n_rd, n_wr, sa, sw, sb, to);
        checks++;
        if (to || lat != 2) begin
            errors++;
            $display("FAIL wr_latency: timeout=%0d lat=%0d, required ack 2 cycles after req", to, lat);
        end
        checks++;
        if (n_wr != 1 || n_rd != 0 || sa !== 18'h00008 || sw !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL wr_strobe: n_wr=%0d n_rd=%0d addr=%h data=%h, required 1 0 00008 ffffffff",
                     n_wr, n_rd, sa, sw);
        end
        run_single(0, 1'b0, 1'b0, 18'h00008, 32'h0, lat, n_rd, n_wr, sa, sw, sb, to);
        checks++;
        if (to || lat != 2 || n_rd != 1 || n_wr != 0) begin
            errors++;
            $display("FAIL rd_strobe: timeout=%0d lat=%0d n_rd=%0d n_wr=%0d, required 0 2 1 0",
                     to, lat, n_rd, n_wr);
        end
        checks++;
        if (r0_rdata !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL rd_data: r0_rdata=%h, required ffffffff", r0_rdata);
        end
    endtask

    task automatic test_contention();
        int first, gap, exp_first; bit to;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            exp_first = (model_last == 1) ? 0 : 1;
            run_both(1'b1, 18'h00100 + AW'(round), 32'hA0000000 + DW'(round),
                     1'b0, 18'h00008, 32'h0, first, gap, to);
            checks++;
            if (to || first != exp_first || gap != 3) begin
                errors++;
                $display("FAIL contention_r%0d: timeout=%0d first=%0d gap=%0d, required first=%0d gap=3",
                         round, to, first, gap, exp_first);
            end
            checks++;
            if (r1_rdata !== exp_rdata[1]) begin
                errors++;
                $display("FAIL contention_rd%0d: r1_rdata=%h, required %h", round, r1_rdata, exp_rdata[1]);
            end
        end
    endtask

    task automatic test_byte_read();
        int lat, n_rd, n_wr; logic [AW-1:0] sa; logic [DW-1:0] sw; logic sb; bit to;
        logic [DW-1:0] r0_before;
        r0_before = r0_rdata;
        run_single(1, 1'b0, 1'b1, 18'h00010, 32'h0, lat, n_rd, n_wr, sa, sw, sb, to);
        checks++;
        if (to || n_rd != 1 || n_wr != 0 || sb !== 1'b1 || sa !== 18'h00010) begin
            errors++;
            $display("FAIL byte_rd_strobe: timeout=%0d n_rd=%0d n_wr=%0d byte=%b addr=%h, required 0 1 0 1 00010",
                     to, n_rd, n_wr, sb, sa);
        end
        checks++;
        if (r1_rdata !== exp_rdata[1] || r0_rdata !== r0_before) begin
            errors++;
            $display("FAIL byte_rd_data: r1=%h r0=%h, required r1=%h r0=%h",
                     r1_rdata, r0_rdata, exp_rdata[1], r0_before);
        end
    endtask

    task automatic test_reset_mid_access();
        int n_wr; bit got;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 18'h00020, 32'hA5A5_5A5A);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: mem_write=%b, required 1 in ACCESS", mem_write);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_write, mem_read, r0_ack, r1_ack, busy} !== 5'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset: strobes/acks/busy=%b addr=%h, required 00000 0",
                     {mem_write, mem_read, r0_ack, r1_ack, busy}, mem_addr);
        end
        reset = 1'b0;
        model_reset();
        got = 0; n_wr = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (mem_write) n_wr++;
            if (r0_ack) begin got = 1; r0_req = 1'b0; break; end
        end
        r0_req = 1'b0;
        checks++;
        if (!got || n_wr != 1) begin
            errors++;
            $display("FAIL mid_reserve: acked=%0d n_wr=%0d, required 1 1", got, n_wr);
        end
        if (got) model_apply(0, 1'b1, 18'h00020, 32'hA5A5_5A5A);
    endtask

    task automatic test_random();
        int lat, n_rd, n_wr, first, gap, exp_first, mode, port;
        logic [AW-1:0] sa, a0, a1; logic [DW-1:0] sw, d0, d1; logic sb; bit to, we0, we1;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            a0 = AW'($urandom); a0[9:0] = 10'($urandom_range(0, 15));
            a1 = AW'($urandom); a1[9:0] = 10'($urandom_range(0, 15));
            d0 = $urandom; d1 = $urandom;
            we0 = 1'($urandom); we1 = 1'($urandom);
            if (mode < 2) begin
                port = mode;
                run_single(port, we0, 1'($urandom), a0, d0, lat, n_rd, n_wr, sa, sw, sb, to);
                checks++;
                if (to || lat != 2 || sa !== a0 || n_rd != int'(!we0) || n_wr != int'(we0) ||
                    (we0 && sw !== d0)) begin
                    errors++;
                    $display("FAIL rand_single%0d: port=%0d to=%0d lat=%0d addr=%h n_rd=%0d n_wr=%0d, required addr=%h we=%0d",
                             it, port, to, lat, sa, n_rd, n_wr, a0, we0);
                end
            end else begin
                exp_first = (model_last == 1) ? 0 : 1;
                run_both(we0, a0, d0, we1, a1, d1, first, gap, to);
                checks++;
                if (to || first != exp_first || gap != 3) begin
                    errors++;
                    $display("FAIL rand_both%0d: to=%0d first=%0d gap=%0d, required first=%0d gap=3",
                             it, to, first, gap, exp_first);
                end
            end
            checks++;
            if (r0_rdata !== exp_rdata[0] || r1_rdata !== exp_rdata[1]) begin
                errors++;
                $display("FAIL rand_rdata%0d: r0=%h r1=%h, required r0=%h r1=%h",
                         it, r0_rdata, r1_rdata, exp_rdata[0], exp_rdata[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_byte = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_byte = 1'b0; r1_addr = '0; r1_wdata = '0;
        model_reset();

        test_reset();
        test_write_read();
        test_contention();
        test_byte_read();
        test_reset_mid_access();
        test_random();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
